text_plane_writer: RTL and testbench
====================================

# text_plane_writer

Writer side of the text-mode display. Accepts a byte stream (keyboard/UART decoder output) over a valid/ready handshake, interprets printable and control bytes, and drives the CharacterPlane write port (row, col, character id, write enable) while tracking a cursor. PixelEncoder reads the plane; this block is the only agent that fills it.

## Interface
- ROW_NUMBER, 15, text rows on screen
- COL_NUMBER, 40, characters per row
- CHAR_ID_LENGTH, 8, character id width
- ROW_BIT_LEN, 4, row index width (≥ clog2(ROW_NUMBER))
- COL_BIT_LEN, 6, column index width (≥ clog2(COL_NUMBER))
- BLANK_CHAR, 8'h20, id written by backspace and clear

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  byte present on in_char
- in_char  in  CHAR_ID_LENGTH  input byte
- in_ready  out  1  block can accept a byte this cycle
- wr_en  out  1  plane write strobe, one cycle per write
- wr_row  out  ROW_BIT_LEN  plane write row
- wr_col  out  COL_BIT_LEN  plane write column
- wr_char  out  CHAR_ID_LENGTH  plane write character id
- cursor_row  out  ROW_BIT_LEN  current cursor row
- cursor_col  out  COL_BIT_LEN  current cursor column

## Operation
- States: IDLE, CLEAR. Reset → IDLE, cursor (0,0), wr_en 0, wr_row/wr_col/wr_char 0.
- in_ready = 1 in IDLE, 0 in CLEAR. Byte accepted on an edge where in_valid & in_ready.
- Printable 0x20–0x7E: write in_char at cursor; advance cursor.
- Advance: col+1; at col COL_NUMBER-1 → col 0, row+1; at row ROW_NUMBER-1 → row 0 (wrap to top, no scroll).
- 0x0A or 0x0D: no write; col 0, row+1 with same row wrap. 0x0D immediately after 0x0A (or vice versa) is not merged; each moves a row.
- 0x08 backspace: retreat cursor (col>0 → col-1; col 0 & row>0 → row-1, col COL_NUMBER-1; at (0,0) stay), write BLANK_CHAR at the new position. At (0,0) the blank is still written at (0,0).
- 0x0C: enter CLEAR (see Configuration).
- Any other byte: accepted, dropped; no write, cursor unchanged.
- CLEAR: writes BLANK_CHAR to every cell, row-major from (0,0) to (ROW_NUMBER-1, COL_NUMBER-1), one cell per cycle, then cursor (0,0), return IDLE.
- Reset in any state (including mid-CLEAR): abort immediately to reset values; partially cleared plane left as is.

## Timing
- Write latency: byte accepted at edge N → wr_en high for cycle N..N+1 with registered row/col/char; cursor_* updated at same edge N.
- Throughput in IDLE: one byte per cycle; back-to-back printables give consecutive wr_en cycles at consecutive positions.
- wr_en low in all cycles without a write; wr_row/wr_col/wr_char hold last value when wr_en low.
- CLEAR: 0x0C accepted at edge N; in_ready low from N; wr_en high for exactly ROW_NUMBER×COL_NUMBER cycles (600 default); in_ready high again the cycle after the last clear write; cursor (0,0) from that cycle.
- All index arithmetic is mod-bounded by compare against ROW_NUMBER-1/COL_NUMBER-1, never by bit overflow.

## Configuration
- TEXT_PLANE_WRITER_CLEAR_EN defined: 0x0C triggers CLEAR as above.
- Not defined: CLEAR state and its counters are not compiled; 0x0C is dropped like any other unknown byte; in_ready is constant 1 after reset.

## Structure
- Shared package text_plane_pkg: ROW_NUMBER, COL_NUMBER, CHAR_ID_LENGTH, ROW_BIT_LEN, COL_BIT_LEN, BLANK_CHAR, control-byte constants (CHAR_BS 8'h08, CHAR_LF 8'h0A, CHAR_FF 8'h0C, CHAR_CR 8'h0D), state enum.
- One sub-module: text_cursor_step, combinational next-position (advance/retreat/newline with wrap); instantiated once, shared by IDLE path and CLEAR sweep.

## Test plan
- Reset, send "HI" back-to-back → wr_en two cycles: (0,0,0x48), (0,1,0x49); cursor (0,2).
- 40 printables from (0,0) then 'A' → 40th write at (0,39), 'A' at (1,0); cursor (1,1). From (14,39) one printable → cursor (0,0).
- At (3,0) send 0x08 → write 0x20 at (2,39), cursor (2,39); at (0,0) send 0x08 → write 0x20 at (0,0), cursor stays.
- At (5,7) send 0x0D → no wr_en, cursor (6,0); send 0x01 → accepted, no write, cursor unchanged.
- With CLEAR_EN: send 0x0C at (4,4) → in_ready low, 600 wr_en cycles of 0x20 ending at (14,39), then in_ready high, cursor (0,0); without CLEAR_EN: 0x0C → no write, cursor (4,4).
- Assert reset at clear cycle 100 → next cycle wr_en 0, in_ready 1, cursor (0,0); subsequent 'Z' written at (0,0).

Source files
------------

// File: rtl/text_plane_pkg.sv
// rtl/text_plane_pkg.sv - shared geometry, control bytes, state and step types for the text plane writer
package text_plane_pkg;

    localparam int ROW_NUMBER     = 15;
    localparam int COL_NUMBER     = 40;
    localparam int CHAR_ID_LENGTH = 8;
    localparam int ROW_BIT_LEN    = 4;
    localparam int COL_BIT_LEN    = 6;

    localparam logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20;
    localparam logic [CHAR_ID_LENGTH-1:0] CHAR_BS    = 8'h08;
    localparam logic [CHAR_ID_LENGTH-1:0] CHAR_LF    = 8'h0A;
    localparam logic [CHAR_ID_LENGTH-1:0] CHAR_FF    = 8'h0C;
    localparam logic [CHAR_ID_LENGTH-1:0] CHAR_CR    = 8'h0D;

    localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
    localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } writer_state_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_ADVANCE,
        STEP_RETREAT,
        STEP_NEWLINE
    } step_op_t;

    // Cursor movement implied by one input byte; bytes that move nothing map to STEP_HOLD.
    function automatic step_op_t byte_op(input logic [CHAR_ID_LENGTH-1:0] ch);
        if ((ch >= 8'h20) && (ch <= 8'h7E)) begin
            return STEP_ADVANCE;
        end else if ((ch == CHAR_LF) || (ch == CHAR_CR)) begin
            return STEP_NEWLINE;
        end else if (ch == CHAR_BS) begin
            return STEP_RETREAT;
        end
        return STEP_HOLD;
    endfunction

endpackage

// File: rtl/text_plane_writer_if.sv
// rtl/text_plane_writer_if.sv - byte stream input, plane write port and cursor of the text plane writer
interface text_plane_writer_if;
    import text_plane_pkg::*;

    logic                      in_valid;
    logic [CHAR_ID_LENGTH-1:0] in_char;
    logic                      in_ready;
    logic                      wr_en;
    logic [ROW_BIT_LEN-1:0]    wr_row;
    logic [COL_BIT_LEN-1:0]    wr_col;
    logic [CHAR_ID_LENGTH-1:0] wr_char;
    logic [ROW_BIT_LEN-1:0]    cursor_row;
    logic [COL_BIT_LEN-1:0]    cursor_col;

    modport master (
        output in_valid, in_char,
        input  in_ready, wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col
    );

    modport slave (
        input  in_valid, in_char,
        output in_ready, wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col
    );

endinterface

// File: rtl/text_cursor_step.sv
// rtl/text_cursor_step.sv - combinational next cell position: advance, retreat or newline with wrap
module text_cursor_step
    import text_plane_pkg::*;
(
    input  logic [ROW_BIT_LEN-1:0] row,
    input  logic [COL_BIT_LEN-1:0] col,
    input  step_op_t               op,
    output logic [ROW_BIT_LEN-1:0] next_row,
    output logic [COL_BIT_LEN-1:0] next_col
);

    // Bottom row wraps to the top; the screen never scrolls.
    logic [ROW_BIT_LEN-1:0] row_down;
    assign row_down = (row == ROW_LAST) ? '0 : row + 1'b1;

    always_comb begin
        next_row = row;
        next_col = col;
        case (op)
            STEP_ADVANCE: begin
                if (col == COL_LAST) begin
                    next_row = row_down;
                    next_col = '0;
                end else begin
                    next_col = col + 1'b1;
                end
            end
            STEP_NEWLINE: begin
                next_row = row_down;
                next_col = '0;
            end
            STEP_RETREAT: begin
                if (col != '0) begin
                    next_col = col - 1'b1;
                end else if (row != '0) begin
                    next_row = row - 1'b1;
                    next_col = COL_LAST;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/text_plane_writer.sv
// rtl/text_plane_writer.sv - byte stream to character plane writer with cursor; TEXT_PLANE_WRITER_CLEAR_EN enables form-feed clear
module text_plane_writer
    import text_plane_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    text_plane_writer_if.slave bus
);

    logic [ROW_BIT_LEN-1:0]    cursor_row;
    logic [COL_BIT_LEN-1:0]    cursor_col;
    logic                      wr_en;
    logic [ROW_BIT_LEN-1:0]    wr_row;
    logic [COL_BIT_LEN-1:0]    wr_col;
    logic [CHAR_ID_LENGTH-1:0] wr_char;

    logic [ROW_BIT_LEN-1:0]    step_row;
    logic [COL_BIT_LEN-1:0]    step_col;
    logic [ROW_BIT_LEN-1:0]    next_row;
    logic [COL_BIT_LEN-1:0]    next_col;
    step_op_t                  step_op;
    logic                      accept;

`ifdef TEXT_PLANE_WRITER_CLEAR_EN
    writer_state_t             state;
    logic [ROW_BIT_LEN-1:0]    clear_row;
    logic [COL_BIT_LEN-1:0]    clear_col;
    logic                      clear_done;

    assign bus.in_ready = (state == ST_IDLE);
`else
    assign bus.in_ready = 1'b1;
`endif

    assign accept = bus.in_valid & bus.in_ready;

    // The single step unit follows the sweep pointer while clearing, else the cursor.
    always_comb begin
        step_row = cursor_row;
        step_col = cursor_col;
        step_op  = STEP_HOLD;
`ifdef TEXT_PLANE_WRITER_CLEAR_EN
        if (state == ST_CLEAR) begin
            step_row = clear_row;
            step_col = clear_col;
            step_op  = STEP_ADVANCE;
        end else if (accept) begin
            step_op = byte_op(bus.in_char);
        end
`else
        if (accept) begin
            step_op = byte_op(bus.in_char);
        end
`endif
    end

    text_cursor_step u_step (
        .row      (step_row),
        .col      (step_col),
        .op       (step_op),
        .next_row (next_row),
        .next_col (next_col)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cursor_row <= '0;
            cursor_col <= '0;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_char    <= '0;
`ifdef TEXT_PLANE_WRITER_CLEAR_EN
            state      <= ST_IDLE;
            clear_row  <= '0;
            clear_col  <= '0;
            clear_done <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
`ifdef TEXT_PLANE_WRITER_CLEAR_EN
            if (state == ST_CLEAR) begin
                if (clear_done) begin
                    state      <= ST_IDLE;
                    clear_done <= 1'b0;
                    cursor_row <= '0;
                    cursor_col <= '0;
                end else begin
                    wr_en      <= 1'b1;
                    wr_row     <= clear_row;
                    wr_col     <= clear_col;
                    wr_char    <= BLANK_CHAR;
                    clear_row  <= next_row;
                    clear_col  <= next_col;
                    clear_done <= (clear_row == ROW_LAST) && (clear_col == COL_LAST);
                end
            end else if (accept && (bus.in_char == CHAR_FF)) begin
                // Cell (0,0) is blanked on the accepting edge, so the sweep resumes at (0,1).
                state      <= ST_CLEAR;
                wr_en      <= 1'b1;
                wr_row     <= '0;
                wr_col     <= '0;
                wr_char    <= BLANK_CHAR;
                clear_row  <= '0;
                clear_col  <= COL_BIT_LEN'(1);
                clear_done <= 1'b0;
            end else
`endif
            if (accept) begin
                cursor_row <= next_row;
                cursor_col <= next_col;
                case (step_op)
                    STEP_ADVANCE: begin
                        wr_en   <= 1'b1;
                        wr_row  <= cursor_row;
                        wr_col  <= cursor_col;
                        wr_char <= bus.in_char;
                    end
                    STEP_RETREAT: begin
                        wr_en   <= 1'b1;
                        wr_row  <= next_row;
                        wr_col  <= next_col;
                        wr_char <= BLANK_CHAR;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.wr_row     = wr_row;
    assign bus.wr_col     = wr_col;
    assign bus.wr_char    = wr_char;
    assign bus.cursor_row = cursor_row;
    assign bus.cursor_col = cursor_col;

endmodule

// File: tb/tb_text_plane_writer.sv
// tb/tb_text_plane_writer.sv - self-checking bench: vector table, write scoreboard and cursor model
module tb_text_plane_writer;
    import text_plane_pkg::*;

    localparam int CELLS = ROW_NUMBER * COL_NUMBER;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_plane_writer_if bus ();

    text_plane_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [ROW_BIT_LEN-1:0]    row;
        logic [COL_BIT_LEN-1:0]    col;
        logic [CHAR_ID_LENGTH-1:0] ch;
    } wr_t;

    typedef struct {
        logic [7:0] ch;
        bit         wr;
        int         wrow;
        int         wcol;
        logic [7:0] wch;
        int         crow;
        int         ccol;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[11];
    int   tests = 0;
    int   fails = 0;
    int   writes_seen = 0;
    int   m_pos = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int r, input int c, input logic [7:0] ch);
        wr_t w;
        w.row = ROW_BIT_LEN'(r);
        w.col = COL_BIT_LEN'(c);
        w.ch  = ch;
        exp_q.push_back(w);
    endtask

    // Every plane write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_row", int'(bus.wr_row), int'(e.row));
                check("wr_col", int'(bus.wr_col), int'(e.col));
                check("wr_char", int'(bus.wr_char), int'(e.ch));
            end
        end
    end

    task automatic drive_byte(input logic [7:0] c);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, int'(bus.cursor_row), r);
        check({name, "_col"}, int'(bus.cursor_col), c);
    endtask

    // Reference cursor kept as a linear cell index.
    task automatic send(input logic [7:0] c);
        int r;
        int col;
        r   = m_pos / COL_NUMBER;
        col = m_pos % COL_NUMBER;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(r, col, c);
            m_pos = (m_pos + 1) % CELLS;
        end else if (c == CHAR_LF || c == CHAR_CR) begin
            m_pos = ((r + 1) % ROW_NUMBER) * COL_NUMBER;
        end else if (c == CHAR_BS) begin
            if (m_pos > 0) m_pos--;
            push_wr(m_pos / COL_NUMBER, m_pos % COL_NUMBER, BLANK_CHAR);
        end
        drive_byte(c);
        check("in_ready", int'(bus.in_ready), 1);
        check_cursor("cursor", m_pos / COL_NUMBER, m_pos % COL_NUMBER);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_pos = 0;
    endtask

    initial begin
        int base;
        int k;
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_row", int'(bus.wr_row), 0);
        check("rst_wr_col", int'(bus.wr_col), 0);
        check("rst_wr_char", int'(bus.wr_char), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check_cursor("rst_cursor", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        tbl[0]  = '{8'h48, 1'b1, 0, 0,  8'h48, 0, 1};
        tbl[1]  = '{8'h49, 1'b1, 0, 1,  8'h49, 0, 2};
        tbl[2]  = '{8'h01, 1'b0, 0, 0,  8'h00, 0, 2};
        tbl[3]  = '{8'h0D, 1'b0, 0, 0,  8'h00, 1, 0};
        tbl[4]  = '{8'h0A, 1'b0, 0, 0,  8'h00, 2, 0};
        tbl[5]  = '{8'h08, 1'b1, 1, 39, 8'h20, 1, 39};
        tbl[6]  = '{8'h7E, 1'b1, 1, 39, 8'h7E, 2, 0};
        tbl[7]  = '{8'h7F, 1'b0, 0, 0,  8'h00, 2, 0};
        tbl[8]  = '{8'h1F, 1'b0, 0, 0,  8'h00, 2, 0};
        tbl[9]  = '{8'h20, 1'b1, 2, 0,  8'h20, 2, 1};
        tbl[10] = '{8'h08, 1'b1, 2, 0,  8'h20, 2, 0};
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) push_wr(tbl[i].wrow, tbl[i].wcol, tbl[i].wch);
            drive_byte(tbl[i].ch);
            check_cursor("tbl_cursor", tbl[i].crow, tbl[i].ccol);
        end
        release_bus();
        @(posedge clk);
        #1;
        check("idle_wr_en", int'(bus.wr_en), 0);
        check("hold_wr_row", int'(bus.wr_row), 2);
        check("hold_wr_col", int'(bus.wr_col), 0);
        check("hold_wr_char", int'(bus.wr_char), 32);

        // Row wrap at end of line, then bottom-right wrap to top.
        do_reset();
        for (int i = 0; i < 40; i++) send(8'h61 + 8'(i % 26));
        send(8'h41);
        check_cursor("after_41", 1, 1);
        for (int i = 0; i < 13; i++) send(CHAR_LF);
        for (int i = 0; i < 39; i++) send(8'h30 + 8'(i % 10));
        check_cursor("at_14_39", 14, 39);
        send(8'h23);
        check_cursor("wrap_top", 0, 0);
        send(CHAR_BS);
        check_cursor("bs_origin", 0, 0);
        for (int i = 0; i < 3; i++) send(CHAR_LF);
        send(CHAR_BS);
        check_cursor("bs_row_up", 2, 39);

        // CR then LF each take a row.
        do_reset();
        for (int i = 0; i < 5; i++) send(CHAR_LF);
        for (int i = 0; i < 7; i++) send(8'h6B);
        send(CHAR_CR);
        check_cursor("cr", 6, 0);
        send(CHAR_LF);
        check_cursor("lf_after_cr", 7, 0);
        send(8'h01);
        check_cursor("dropped", 7, 0);

        do_reset();
        for (int i = 0; i < 4; i++) send(CHAR_LF);
        for (int i = 0; i < 4; i++) send(8'h2E);
        check_cursor("at_4_4", 4, 4);

`ifdef TEXT_PLANE_WRITER_CLEAR_EN
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = CHAR_FF;
        for (int r = 0; r < ROW_NUMBER; r++)
            for (int c = 0; c < COL_NUMBER; c++)
                push_wr(r, c, BLANK_CHAR);
        base = writes_seen;
        @(posedge clk);
        #1;
        check("ready_in_clear", int'(bus.in_ready), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("clear_cycles", k, CELLS);
        check("clear_writes", writes_seen - base, CELLS);
        check("clear_q_empty", exp_q.size(), 0);
        check("clear_wr_en", int'(bus.wr_en), 0);
        check_cursor("clear_cursor", 0, 0);
        m_pos = 0;

        // Reset on clear cycle 100 aborts the sweep.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = CHAR_FF;
        for (int i = 0; i < CELLS; i++) push_wr(i / COL_NUMBER, i % COL_NUMBER, BLANK_CHAR);
        base = writes_seen;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", int'(bus.wr_en), 0);
        check("abort_in_ready", int'(bus.in_ready), 1);
        check_cursor("abort_cursor", 0, 0);
        check("abort_writes", writes_seen - base, 100);
        exp_q.delete();
        reset = 1'b0;
        m_pos = 0;
`else
        send(CHAR_FF);
        check_cursor("ff_dropped", 4, 4);
        release_bus();
        @(posedge clk);
        #1;
        check("ff_no_write", int'(bus.wr_en), 0);
        check("ff_in_ready", int'(bus.in_ready), 1);

        // Reset in the middle of traffic.
        send(8'h78);
        send(8'h79);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", int'(bus.wr_en), 0);
        check("abort_in_ready", int'(bus.in_ready), 1);
        check_cursor("abort_cursor", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_pos = 0;
`endif
        send(8'h5A);
        check_cursor("after_z", 0, 1);
        release_bus();
        repeat (3) @(posedge clk);
        #1;
        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
